// File: rtl/conv_stream_dispatch.sv
// Routes a counted burst from one input stream to one of N_DEST outputs through a
// single register stage, with an independent fixed-delay start-pulse line per destination.
module conv_stream_dispatch #(
    parameter int DATA_W      = 128,
    parameter int N_DEST      = 2,
    parameter int DEST_W      = 1,
    parameter int LEN_W       = 20,
    parameter int START_DELAY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DEST_W-1:0] cmd_dest,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              abort,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [N_DEST-1:0] m_valid,
    input  logic [N_DEST-1:0] m_ready,
    output logic              m_last,
    input  logic [N_DEST-1:0] start_in,
    output logic [N_DEST-1:0] start_out,
    output logic              busy,
    output logic              done,
    output logic              err_dest
);

    typedef enum logic [1:0] {IDLE, ROUTE, DRAIN} state_t;

    // One extra bit so the range check stays meaningful when N_DEST is a power of two.
    localparam logic [DEST_W:0] N_DEST_EXT = (DEST_W + 1)'(N_DEST);

    state_t            state, state_nxt;
    logic [DEST_W-1:0] dest;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  cnt;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_last;
    logic              zero_done;
    logic              drain_done;
    logic              cmd_acc;
    logic              cmd_bad;
    logic              beat_acc;
    logic              beat_last;
    logic              out_ready;

    assign out_ready = m_ready[dest];
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign cmd_bad   = {1'b0, cmd_dest} >= N_DEST_EXT;
    assign beat_acc  = s_valid && s_ready;
    assign beat_last = (cnt + LEN_W'(1)) == len;

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        s_ready    = 1'b0;
        drain_done = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !zero_done;
                if (cmd_valid && cmd_ready && !cmd_bad && (cmd_len != '0))
                    state_nxt = ROUTE;
            end
            ROUTE: begin
                s_ready = !out_valid || out_ready;
                if (abort)
                    state_nxt = IDLE;
                else if (s_valid && s_ready && beat_last)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                // Abort wins over a simultaneous final handshake.
                drain_done = out_valid && out_last && out_ready && !abort;
                if (abort || drain_done)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dest      <= '0;
            len       <= '0;
            cnt       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            zero_done <= 1'b0;
            err_dest  <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            if (cmd_acc) begin
                dest <= cmd_dest;
                len  <= cmd_len;
                cnt  <= '0;
                if (cmd_bad) begin
                    err_dest <= 1'b1;
                end else begin
                    err_dest  <= 1'b0;
                    zero_done <= (cmd_len == '0);
                end
            end
            if (abort && (state != IDLE)) begin
                out_valid <= 1'b0;
                cnt       <= '0;
            end else if (beat_acc) begin
                out_data  <= s_data;
                out_valid <= 1'b1;
                out_last  <= beat_last;
                cnt       <= cnt + LEN_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        m_valid = '0;
        for (int i = 0; i < N_DEST; i++)
            m_valid[i] = out_valid && (dest == DEST_W'(i));
    end

    assign m_data = out_data;
    assign m_last = out_valid && out_last;
    assign done   = zero_done || drain_done;
    assign busy   = (state != IDLE);

    generate
        if (START_DELAY == 0) begin : g_start_pass
            assign start_out = start_in;
        end else begin : g_start_dly
            logic [N_DEST-1:0] pipe [START_DELAY];
            // NOTE: the delay line is reset stage by stage so a reset also cancels
            // pulses already in flight; ordinary storage arrays would not be reset.
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < START_DELAY; k++) pipe[k] <= '0;
                end else begin
                    pipe[0] <= start_in;
                    for (int k = 1; k < START_DELAY; k++) pipe[k] <= pipe[k-1];
                end
            end
            assign start_out = pipe[START_DELAY-1];
        end
    endgenerate

endmodule
